// File: rtl/mem_stage_if.sv
// Handshake and write-back bundle between execute, the memory stage and write-back.
// master = upstream/write-back side, slave = the memory stage itself.
interface mem_stage_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic        ex_load;
    logic        ex_store;
    logic        ex_byte;
    logic [3:0]  ex_rd;
    logic        ex_rf_en;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [3:0]  wb_rd;
    logic        wb_rf_en;
    logic        align_fault;

    modport master (
        output ex_valid, ex_result, ex_store_data, ex_load, ex_store, ex_byte, ex_rd, ex_rf_en,
        input  ex_ready, wb_valid, wb_data, wb_rd, wb_rf_en, align_fault
    );

    modport slave (
        input  ex_valid, ex_result, ex_store_data, ex_load, ex_store, ex_byte, ex_rd, ex_rf_en,
        output ex_ready, wb_valid, wb_data, wb_rd, wb_rf_en, align_fault
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX/MEM latch, fixed-latency little-endian byte RAM, registered write-back.
// Define MEM_ALIGN_CHECK_EN to flag misaligned word accesses instead of silently aligning them.
module mem_stage #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_stage_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(WAIT_CYCLES + 2);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    logic [ADDR_W-1:0]  addr_reg;
    logic [31:0]        store_data_reg;
    logic               load_reg, store_reg, byte_reg, rf_en_reg;
    logic [3:0]         rd_reg;

    logic               wb_valid_reg, wb_valid_next;
    logic [31:0]        wb_data_reg, wb_data_next;
    logic [3:0]         wb_rd_reg, wb_rd_next;
    logic               wb_rf_en_reg, wb_rf_en_next;
    logic               fault_reg, fault_next;

    logic [7:0]         mem [DEPTH];
    logic [ADDR_W-3:0]  word_hi;
    logic [31:0]        word_rd;
    logic [7:0]         byte_rd;
    logic [3:0]         lane_we;
    logic [3:0][7:0]    lane_din;
    logic               misaligned;
    logic               mem_we;
    logic               transfer;
    logic               is_mem_in;

    assign transfer  = bus.ex_valid && (state_reg == IDLE);
    assign is_mem_in = bus.ex_load || bus.ex_store;
    assign word_hi   = addr_reg[ADDR_W-1:2];
    assign byte_rd   = mem[addr_reg];

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = !byte_reg && (addr_reg[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // A store racing an asserted reset must never reach the array.
    assign mem_we = (state_reg == ACCESS) && store_reg && !load_reg && !misaligned && rst_n;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_we[gi]        = mem_we && (!byte_reg || addr_reg[1:0] == 2'(gi));
            assign lane_din[gi]       = byte_reg ? store_data_reg[7:0] : store_data_reg[8*gi +: 8];
            assign word_rd[8*gi +: 8] = mem[{word_hi, 2'(gi)}];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) begin
                mem[{word_hi, 2'(i)}] <= lane_din[i];
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        wb_valid_next = 1'b0;
        wb_data_next  = wb_data_reg;
        wb_rd_next    = wb_rd_reg;
        wb_rf_en_next = wb_rf_en_reg;
        fault_next    = fault_reg;
        case (state_reg)
            IDLE: begin
                if (transfer) begin
                    if (!is_mem_in) begin
                        wb_valid_next = 1'b1;
                        wb_data_next  = bus.ex_result;
                        wb_rd_next    = bus.ex_rd;
                        wb_rf_en_next = bus.ex_rf_en;
                        fault_next    = 1'b0;
                    end else if (WAIT_CYCLES == 0) begin
                        state_next = ACCESS;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                state_next    = IDLE;
                wb_valid_next = 1'b1;
                wb_rd_next    = rd_reg;
                fault_next    = misaligned;
                if (load_reg && !misaligned) begin
                    wb_data_next  = byte_reg ? {24'd0, byte_rd} : word_rd;
                    wb_rf_en_next = rf_en_reg;
                end else begin
                    wb_data_next  = 32'd0;
                    wb_rf_en_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            addr_reg       <= '0;
            store_data_reg <= '0;
            load_reg       <= 1'b0;
            store_reg      <= 1'b0;
            byte_reg       <= 1'b0;
            rf_en_reg      <= 1'b0;
            rd_reg         <= '0;
            wb_valid_reg   <= 1'b0;
            wb_data_reg    <= '0;
            wb_rd_reg      <= '0;
            wb_rf_en_reg   <= 1'b0;
            fault_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            wb_valid_reg <= wb_valid_next;
            wb_data_reg  <= wb_data_next;
            wb_rd_reg    <= wb_rd_next;
            wb_rf_en_reg <= wb_rf_en_next;
            fault_reg    <= fault_next;
            if (transfer) begin
                addr_reg       <= bus.ex_result[ADDR_W-1:0];
                store_data_reg <= bus.ex_store_data;
                load_reg       <= bus.ex_load;
                store_reg      <= bus.ex_store;
                byte_reg       <= bus.ex_byte;
                rf_en_reg      <= bus.ex_rf_en;
                rd_reg         <= bus.ex_rd;
            end
        end
    end

    assign bus.ex_ready    = (state_reg == IDLE);
    assign bus.wb_valid    = wb_valid_reg;
    assign bus.wb_data     = wb_data_reg;
    assign bus.wb_rd       = wb_rd_reg;
    assign bus.wb_rf_en    = wb_rf_en_reg;
    assign bus.align_fault = fault_reg;
endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage: ALU pass-through, word/byte loads and stores,
// address wrap, alignment behaviour and reset abort of an in-flight store.
module tb_mem_stage;
    localparam int WAIT_CYCLES = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_stage_if bus();

    mem_stage #(.ADDR_W(8), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  rd;
        logic        rf_en;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic ld, input logic st, input logic by, input logic [31:0] res,
                         input logic [31:0] sdata, input logic [3:0] rd, input logic rf);
        bus.ex_valid      = 1'b1;
        bus.ex_load       = ld;
        bus.ex_store      = st;
        bus.ex_byte       = by;
        bus.ex_result     = res;
        bus.ex_store_data = sdata;
        bus.ex_rd         = rd;
        bus.ex_rf_en      = rf;
    endtask

    task automatic idle_in();
        bus.ex_valid      = 1'b0;
        bus.ex_load       = 1'b0;
        bus.ex_store      = 1'b0;
        bus.ex_byte       = 1'b0;
        bus.ex_result     = 32'd0;
        bus.ex_store_data = 32'd0;
        bus.ex_rd         = 4'd0;
        bus.ex_rf_en      = 1'b0;
    endtask

    task automatic check_wb(input string tag);
        exp_t e;
        chk({tag, "_valid"}, 32'(bus.wb_valid), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_data"},  bus.wb_data, e.data);
            chk({tag, "_rd"},    32'(bus.wb_rd), 32'(e.rd));
            chk({tag, "_rf_en"}, 32'(bus.wb_rf_en), 32'(e.rf_en));
            chk({tag, "_fault"}, 32'(bus.align_fault), 32'(e.fault));
            $display("WB %s rd=%0d data=%h rf_en=%0b fault=%0b", tag, bus.wb_rd, bus.wb_data,
                     bus.wb_rf_en, bus.align_fault);
        end
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_ex_ready"}, 32'(bus.ex_ready), 32'd1);
        chk({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd0);
        chk({tag, "_wb_data"},  bus.wb_data, 32'd0);
        chk({tag, "_wb_rd"},    32'(bus.wb_rd), 32'd0);
        chk({tag, "_wb_rf_en"}, 32'(bus.wb_rf_en), 32'd0);
        chk({tag, "_fault"},    32'(bus.align_fault), 32'd0);
    endtask

    // Called at posedge+1 with the stage idle; returns at posedge+1 after the pulse ends.
    task automatic mem_op(input string tag, input logic ld, input logic st, input logic by,
                          input logic [31:0] addr, input logic [31:0] sdata, input logic [3:0] rd,
                          input logic rf, input logic [31:0] exp_data, input logic exp_rf,
                          input logic exp_fault);
        int lat;
        int ready_low;
        drive(ld, st, by, addr, sdata, rd, rf);
        sb.push_back('{data: exp_data, rd: rd, rf_en: exp_rf, fault: exp_fault});
        @(posedge clk);
        #1;
        idle_in();
        lat = 0;
        ready_low = 0;
        while (!bus.wb_valid && lat < 20) begin
            if (!bus.ex_ready) ready_low++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(WAIT_CYCLES + 1));
        chk({tag, "_ready_low"}, 32'(ready_low), 32'(WAIT_CYCLES + 1));
        chk({tag, "_ready_back"}, 32'(bus.ex_ready), 32'd1);
        check_wb(tag);
        @(posedge clk);
        #1;
        chk({tag, "_pulse_end"}, 32'(bus.wb_valid), 32'd0);
    endtask

    logic [31:0] alu_vals [3];
    int seen_wb;

    initial begin
        alu_vals[0] = 32'h0000_0005;
        alu_vals[1] = 32'h0000_0722;
        alu_vals[2] = 32'hFFFF_FFFF;
        idle_in();
        #3;
        reset_outputs("reset_initial");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back ALU results: one write-back per cycle.
        for (int i = 0; i < 3; i++) begin
            chk("alu_ready", 32'(bus.ex_ready), 32'd1);
            drive(1'b0, 1'b0, 1'b0, alu_vals[i], 32'd0, 4'(i + 1), 1'b1);
            sb.push_back('{data: alu_vals[i], rd: 4'(i + 1), rf_en: 1'b1, fault: 1'b0});
            @(posedge clk);
            #1;
            check_wb("alu");
        end
        idle_in();
        chk("alu_ready_end", 32'(bus.ex_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("alu_pulse_end", 32'(bus.wb_valid), 32'd0);

        mem_op("str_word", 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 4'd5, 1'b1, 32'd0, 1'b0, 1'b0);
        mem_op("ldr_word", 1'b1, 1'b0, 1'b0, 32'h10, 32'd0, 4'd6, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        mem_op("strb", 1'b0, 1'b1, 1'b1, 32'h13, 32'h1234_56AB, 4'd7, 1'b0, 32'd0, 1'b0, 1'b0);
        mem_op("ldrb", 1'b1, 1'b0, 1'b1, 32'h13, 32'd0, 4'd7, 1'b1, 32'h0000_00AB, 1'b1, 1'b0);
        mem_op("ldr_merged", 1'b1, 1'b0, 1'b0, 32'h10, 32'd0, 4'd8, 1'b1, 32'hABAD_BEEF, 1'b1, 1'b0);
        mem_op("ldrb_lane1", 1'b1, 1'b0, 1'b1, 32'h11, 32'd0, 4'd9, 1'b1, 32'h0000_00BE, 1'b1, 1'b0);
        mem_op("ldr_wrap", 1'b1, 1'b0, 1'b0, 32'h0000_0110, 32'd0, 4'd10, 1'b1, 32'hABAD_BEEF, 1'b1, 1'b0);
        mem_op("ld_and_st", 1'b1, 1'b1, 1'b0, 32'h10, 32'h1111_1111, 4'd11, 1'b1, 32'hABAD_BEEF, 1'b1, 1'b0);
        mem_op("ldr_after_ldst", 1'b1, 1'b0, 1'b0, 32'h10, 32'd0, 4'd12, 1'b1, 32'hABAD_BEEF, 1'b1, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
        mem_op("str_misalign", 1'b0, 1'b1, 1'b0, 32'h12, 32'hCAFE_F00D, 4'd13, 1'b1, 32'd0, 1'b0, 1'b1);
        mem_op("ldr_misalign", 1'b1, 1'b0, 1'b0, 32'h11, 32'd0, 4'd14, 1'b1, 32'd0, 1'b0, 1'b1);
        mem_op("ldr_unchanged", 1'b1, 1'b0, 1'b0, 32'h10, 32'd0, 4'd6, 1'b1, 32'hABAD_BEEF, 1'b1, 1'b0);
`else
        mem_op("ldr_misalign", 1'b1, 1'b0, 1'b0, 32'h12, 32'd0, 4'd14, 1'b1, 32'hABAD_BEEF, 1'b1, 1'b0);
        mem_op("ldr_reload", 1'b1, 1'b0, 1'b0, 32'h10, 32'd0, 4'd6, 1'b1, 32'hABAD_BEEF, 1'b1, 1'b0);
`endif

        // Abort: an in-flight store cut off by reset must leave memory untouched.
        mem_op("str_zero", 1'b0, 1'b1, 1'b0, 32'h20, 32'h0000_0000, 4'd1, 1'b0, 32'd0, 1'b0, 1'b0);
        mem_op("ldr_before_abort", 1'b1, 1'b0, 1'b0, 32'h10, 32'd0, 4'd6, 1'b1, 32'hABAD_BEEF, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0000_0055, 4'd2, 1'b0);
        @(posedge clk);
        #1;
        idle_in();
        chk("abort_in_wait", 32'(bus.ex_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        reset_outputs("reset_mid");
        seen_wb = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.wb_valid) seen_wb++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.wb_valid) seen_wb++;
        end
        chk("abort_no_wb", 32'(seen_wb), 32'd0);
        mem_op("ldr_after_abort", 1'b1, 1'b0, 1'b0, 32'h20, 32'd0, 4'd3, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
